// File: rtl/spi_ctrl_pkg.sv
// Shared types for the SPI command scheduler: FSM states, FIFO entry and latched command.
package spi_ctrl_pkg;

    // Owner field sized for the largest supported requester count (8)
    localparam int unsigned OWNER_W = 3;

    typedef enum logic [1:0] {
        IDLE,
        LAUNCH,
        WAIT,
        DONE
    } state_e;

    typedef struct packed {
        logic [7:0]         data;
        logic [OWNER_W-1:0] owner;
        logic               last;
    } rd_entry_t;

    typedef struct packed {
        logic       is_write;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [7:0] nregs;
    } spi_cmd_t;

endpackage

// File: rtl/spi_byte_fifo.sv
// Synchronous FIFO of read-byte entries with zero-latency head and an occupancy count.
module spi_byte_fifo
    import spi_ctrl_pkg::*;
#(
    parameter int unsigned DEPTH = 64
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   push_i,
    input  rd_entry_t              din_i,
    input  logic                   pop_i,
    output rd_entry_t              dout_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] level_o
);
    localparam int unsigned AW = $clog2(DEPTH);

    rd_entry_t      mem_q [DEPTH];
    logic [AW-1:0]  wptr_q;
    logic [AW-1:0]  rptr_q;
    logic [AW:0]    level_q;
    logic           full_c;
    logic           do_push;
    logic           do_pop;

    assign full_c  = (level_q == (AW+1)'(DEPTH));
    assign empty_o = (level_q == '0);
    assign do_push = push_i && !full_c;
    assign do_pop  = pop_i && !empty_o;
    assign dout_o  = mem_q[rptr_q];
    assign level_o = level_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + AW'(1);
            if (do_pop)  rptr_q <= rptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   level_q <= level_q + (AW+1)'(1);
                2'b01:   level_q <= level_q - (AW+1)'(1);
                default: level_q <= level_q;
            endcase
        end
    end

    // Storage needs no reset: the head is only consumed while non-empty
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q] <= din_i;
    end

endmodule

// File: rtl/spi_cmd_scheduler.sv
// Round-robin sharing of one SPI driver between NREQ requesters, with a
// reserved-space read-byte FIFO tagged by owner and last flag.
module spi_cmd_scheduler
    import spi_ctrl_pkg::*;
#(
    parameter int unsigned NREQ           = 2,
    parameter int unsigned FIFO_DEPTH     = 64,
    parameter int unsigned NEWCMD_CYCLES  = 4,
    parameter int unsigned TIMEOUT_CYCLES = 65535,
    parameter int unsigned IDW            = $clog2(NREQ)
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic [NREQ-1:0]               req_valid,
    output logic [NREQ-1:0]               req_ready,
    input  logic [NREQ-1:0]               req_is_write,
    input  logic [NREQ*8-1:0]             req_addr,
    input  logic [NREQ*8-1:0]             req_wdata,
    input  logic [NREQ*8-1:0]             req_nregs,
    output logic [NREQ-1:0]               req_done,
    output logic                          req_err,
    output logic                          drv_new_command,
    output logic                          drv_is_write,
    output logic [7:0]                    drv_addr,
    output logic [7:0]                    drv_wdata,
    output logic [7:0]                    drv_nregs,
    input  logic [7:0]                    drv_rdata,
    input  logic                          drv_rvalid,
    input  logic                          drv_done,
    output logic                          rd_valid,
    input  logic                          rd_ready,
    output logic [7:0]                    rd_data,
    output logic [IDW-1:0]                rd_owner,
    output logic                          rd_last,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
    localparam int unsigned LW  = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned TW  = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned NCW = $clog2(NEWCMD_CYCLES + 1);

    state_e          state_q, state_d;
    logic [IDW-1:0]  rr_q, rr_d;
    logic [IDW-1:0]  owner_q, owner_d;
    spi_cmd_t        cmd_q, cmd_d;
    logic [TW-1:0]   tmr_q, tmr_d;
    logic [NCW-1:0]  lcnt_q, lcnt_d;
    logic [7:0]      bcnt_q, bcnt_d;
    logic            err_q, err_d;
    logic [LW-1:0]   resv_q, resv_d;
    logic            hold_q, hold_d;
    logic [NREQ-1:0] req_ready_q, req_ready_d;
    logic [NREQ-1:0] req_done_q, req_done_d;
    logic            req_err_q, req_err_d;
    logic            ncmd_q, busy_q;

    logic            found_c;
    logic [IDW-1:0]  win_c, cand_c;
    spi_cmd_t        win_cmd_c, cand_cmd_c;
    logic [LW-1:0]   free_c;
    logic [7:0]      bcnt_nx;
    logic            err_nx;
    logic            push_c;
    rd_entry_t       push_entry_c;
    rd_entry_t       head_w, head_c;
    logic            empty_w;
    logic [LW-1:0]   level_w;

    spi_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .rstn    (rstn),
        .push_i  (push_c),
        .din_i   (push_entry_c),
        .pop_i   (rd_ready),
        .dout_o  (head_w),
        .empty_o (empty_w),
        .level_o (level_w)
    );

    // Round-robin search from last_grant+1; reads need free space for every byte
    always_comb begin
        found_c    = 1'b0;
        win_c      = '0;
        win_cmd_c  = '0;
        cand_c     = '0;
        cand_cmd_c = '0;
        free_c     = LW'(FIFO_DEPTH) - level_w - resv_q;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            cand_c     = IDW'((32'(rr_q) + k) % NREQ);
            cand_cmd_c = '{is_write: req_is_write[cand_c],
                           addr:     req_addr[32'(cand_c)*8 +: 8],
                           wdata:    req_wdata[32'(cand_c)*8 +: 8],
                           nregs:    req_nregs[32'(cand_c)*8 +: 8]};
            if (!found_c && req_valid[cand_c] &&
                (cand_cmd_c.is_write || 32'(free_c) >= 32'(cand_cmd_c.nregs))) begin
                found_c   = 1'b1;
                win_c     = cand_c;
                win_cmd_c = cand_cmd_c;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        rr_d         = rr_q;
        owner_d      = owner_q;
        cmd_d        = cmd_q;
        tmr_d        = tmr_q;
        lcnt_d       = lcnt_q;
        bcnt_d       = bcnt_q;
        err_d        = err_q;
        resv_d       = resv_q;
        hold_d       = 1'b0;
        req_ready_d  = '0;
        req_done_d   = '0;
        req_err_d    = 1'b0;
        push_c       = 1'b0;
        push_entry_c = '0;
        bcnt_nx      = bcnt_q;
        err_nx       = err_q;
        unique case (state_q)
            IDLE: begin
                if (hold_q) begin
                    // Zero-length read completes one cycle after its accept
                    req_done_d[owner_q] = 1'b1;
                end else if (found_c) begin
                    req_ready_d[win_c] = 1'b1;
                    rr_d    = win_c;
                    owner_d = win_c;
                    cmd_d   = win_cmd_c;
                    tmr_d   = '0;
                    lcnt_d  = '0;
                    bcnt_d  = '0;
                    err_d   = 1'b0;
                    if (!win_cmd_c.is_write && win_cmd_c.nregs == 8'd0) begin
                        hold_d = 1'b1;
                    end else begin
                        state_d = LAUNCH;
                        if (!win_cmd_c.is_write) resv_d = resv_q + LW'(win_cmd_c.nregs);
                    end
                end
            end
            LAUNCH: begin
                tmr_d = tmr_q + TW'(1);
                if (lcnt_q == NCW'(NEWCMD_CYCLES - 1)) state_d = WAIT;
                else                                   lcnt_d  = lcnt_q + NCW'(1);
            end
            WAIT: begin
                if (drv_rvalid && !cmd_q.is_write) begin
                    if (bcnt_q < cmd_q.nregs) begin
                        push_c       = 1'b1;
                        push_entry_c = '{data:  drv_rdata,
                                         owner: OWNER_W'(owner_q),
                                         last:  (bcnt_q == cmd_q.nregs - 8'd1)};
                        bcnt_nx      = bcnt_q + 8'd1;
                        resv_d       = resv_q - LW'(1);
                    end else begin
                        err_nx = 1'b1;
                    end
                end
                if (drv_done) begin
                    if (!cmd_q.is_write && bcnt_nx != cmd_q.nregs) err_nx = 1'b1;
                    state_d             = DONE;
                    req_done_d[owner_q] = 1'b1;
                    req_err_d           = err_nx;
                end else if (tmr_q >= TW'(TIMEOUT_CYCLES)) begin
                    err_nx              = 1'b1;
                    state_d             = DONE;
                    req_done_d[owner_q] = 1'b1;
                    req_err_d           = 1'b1;
                end else begin
                    tmr_d = tmr_q + TW'(1);
                end
                bcnt_d = bcnt_nx;
                err_d  = err_nx;
            end
            DONE: begin
                // Close rd_last framing of a short read with one pad byte
                if (!cmd_q.is_write && bcnt_q < cmd_q.nregs) begin
                    push_c       = 1'b1;
                    push_entry_c = '{data: 8'h00, owner: OWNER_W'(owner_q), last: 1'b1};
                end
                err_d   = 1'b0;
                resv_d  = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= IDLE;
            rr_q        <= '0;
            owner_q     <= '0;
            cmd_q       <= '0;
            tmr_q       <= '0;
            lcnt_q      <= '0;
            bcnt_q      <= '0;
            err_q       <= 1'b0;
            resv_q      <= '0;
            hold_q      <= 1'b0;
            req_ready_q <= '0;
            req_done_q  <= '0;
            req_err_q   <= 1'b0;
            ncmd_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_q        <= rr_d;
            owner_q     <= owner_d;
            cmd_q       <= cmd_d;
            tmr_q       <= tmr_d;
            lcnt_q      <= lcnt_d;
            bcnt_q      <= bcnt_d;
            err_q       <= err_d;
            resv_q      <= resv_d;
            hold_q      <= hold_d;
            req_ready_q <= req_ready_d;
            req_done_q  <= req_done_d;
            req_err_q   <= req_err_d;
            ncmd_q      <= (state_d == LAUNCH);
            busy_q      <= (state_d != IDLE);
        end
    end

    assign head_c          = empty_w ? '0 : head_w;
    assign req_ready       = req_ready_q;
    assign req_done        = req_done_q;
    assign req_err         = req_err_q;
    assign drv_new_command = ncmd_q;
    assign drv_is_write    = cmd_q.is_write;
    assign drv_addr        = cmd_q.addr;
    assign drv_wdata       = cmd_q.wdata;
    assign drv_nregs       = cmd_q.nregs;
    assign rd_valid        = !empty_w;
    assign rd_data         = head_c.data;
    assign rd_owner        = IDW'(head_c.owner);
    assign rd_last         = head_c.last;
    assign busy            = busy_q;
    assign fifo_level      = level_w;

endmodule

// File: tb/tb_spi_cmd_scheduler.sv
// Directed bench for spi_cmd_scheduler: scoreboarded read FIFO, grants, launch and completion timing.
module tb_spi_cmd_scheduler;
    localparam int unsigned NREQ   = 2;
    localparam int unsigned DEPTH  = 64;
    localparam int unsigned NEWCMD = 4;
    localparam int unsigned TMO    = 100;
    localparam int unsigned IDW    = 1;

    logic                 clk = 1'b0;
    logic                 rstn;
    logic [NREQ-1:0]      req_valid, req_ready, req_is_write, req_done;
    logic [NREQ*8-1:0]    req_addr, req_wdata, req_nregs;
    logic                 req_err, drv_new_command, drv_is_write;
    logic [7:0]           drv_addr, drv_wdata, drv_nregs, drv_rdata, rd_data;
    logic                 drv_rvalid, drv_done, rd_valid, rd_ready, rd_last, busy;
    logic [IDW-1:0]       rd_owner;
    logic [$clog2(DEPTH):0] fifo_level;

    logic [9:0] sb [$];   // expected {data, owner, last}
    int n_pass = 0;
    int n_fail = 0;
    int n_total = 0;

    spi_cmd_scheduler #(
        .NREQ(NREQ), .FIFO_DEPTH(DEPTH), .NEWCMD_CYCLES(NEWCMD), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk), .rstn(rstn),
        .req_valid(req_valid), .req_ready(req_ready), .req_is_write(req_is_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_nregs(req_nregs),
        .req_done(req_done), .req_err(req_err),
        .drv_new_command(drv_new_command), .drv_is_write(drv_is_write),
        .drv_addr(drv_addr), .drv_wdata(drv_wdata), .drv_nregs(drv_nregs),
        .drv_rdata(drv_rdata), .drv_rvalid(drv_rvalid), .drv_done(drv_done),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
        .rd_owner(rd_owner), .rd_last(rd_last), .busy(busy), .fifo_level(fifo_level)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic set_req(input int i, input logic wr, input logic [7:0] a,
                           input logic [7:0] wd, input logic [7:0] nr);
        req_is_write[i]   = wr;
        req_addr[i*8 +: 8]  = a;
        req_wdata[i*8 +: 8] = wd;
        req_nregs[i*8 +: 8] = nr;
        req_valid[i]      = 1'b1;
    endtask

    task automatic issue(input string tag, input int i, input logic wr, input logic [7:0] a,
                         input logic [7:0] wd, input logic [7:0] nr);
        int c = 0;
        set_req(i, wr, a, wd, nr);
        do begin tick(); c++; end while (req_ready == '0 && c < 20);
        chk({tag, ".grant"}, 32'(req_ready), 32'(1) << i);
        req_valid[i] = 1'b0;
    endtask

    // Called in the first launch cycle; returns in the first WAIT cycle
    task automatic launch(input string tag, input logic wr, input logic [7:0] a,
                          input logic [7:0] wd, input logic [7:0] nr);
        int hi = 0;
        chk({tag, ".cmd"}, 32'({drv_is_write, drv_addr, drv_wdata, drv_nregs}), 32'({wr, a, wd, nr}));
        while (drv_new_command && hi < 20) begin hi++; tick(); end
        chk({tag, ".ncmd_len"}, 32'(hi), 32'(NEWCMD));
    endtask

    task automatic send_byte(input logic [7:0] d);
        drv_rdata = d; drv_rvalid = 1'b1; tick(); drv_rvalid = 1'b0;
    endtask

    task automatic pulse_done();
        drv_done = 1'b1; tick(); drv_done = 1'b0;
    endtask

    task automatic wait_done(input string tag, input logic [NREQ-1:0] mask, input logic err);
        int c = 0;
        while (req_done == '0 && c < 10) begin tick(); c++; end
        chk({tag, ".done"}, 32'(req_done), 32'(mask));
        chk({tag, ".err"}, 32'(req_err), 32'(err));
    endtask

    task automatic pop_n(input string tag, input int n);
        logic [9:0] e;
        for (int k = 0; k < n; k++) begin
            e = sb.pop_front();
            chk({tag, ".entry"}, 32'({rd_valid, rd_data, rd_owner, rd_last}), 32'({1'b1, e}));
            rd_ready = 1'b1; tick(); rd_ready = 1'b0;
        end
    endtask

    task automatic drain_all(input string tag);
        pop_n(tag, sb.size());
        chk({tag, ".drained"}, 32'({rd_valid, fifo_level}), 32'(0));
    endtask

    initial begin
        int c;
        int el;
        logic saw;
        logic [NREQ-1:0] exp_g;
        rstn = 1'b0;
        req_valid = '0; req_is_write = '0; req_addr = '0; req_wdata = '0; req_nregs = '0;
        drv_rdata = '0; drv_rvalid = 1'b0; drv_done = 1'b0; rd_ready = 1'b0;
        repeat (3) tick();
        chk("rst.ctl", 32'({req_ready, req_done, req_err, drv_new_command, busy, rd_valid}), 32'(0));
        chk("rst.drv", 32'({drv_is_write, drv_addr, drv_wdata, drv_nregs}), 32'(0));
        chk("rst.fifo", 32'({fifo_level, rd_data, rd_owner, rd_last}), 32'(0));
        rstn = 1'b1;
        tick();

        // Both requesters hold writes; pointer 0 means requester 1 is searched first
        req_is_write = 2'b11;
        req_addr = 16'h2120; req_wdata = 16'hB1B0; req_nregs = '0;
        req_valid = 2'b11;
        for (int g = 0; g < 4; g++) begin
            c = 0;
            while (req_ready == '0 && c < 20) begin tick(); c++; end
            exp_g = (g % 2 == 0) ? 2'b10 : 2'b01;
            chk("rr.grant", 32'(req_ready), 32'(exp_g));
            if (g == 3) req_valid = '0;
            if (g % 2 == 0) launch("rr", 1'b1, 8'h21, 8'hB1, 8'h00);
            else            launch("rr", 1'b1, 8'h20, 8'hB0, 8'h00);
            pulse_done();
            wait_done("rr", exp_g, 1'b0);
            tick();
        end

        issue("wr", 0, 1'b1, 8'h12, 8'hA5, 8'h00);
        launch("wr", 1'b1, 8'h12, 8'hA5, 8'h00);
        pulse_done();
        wait_done("wr", 2'b01, 1'b0);
        tick();
        chk("wr.idle", 32'(busy), 32'(0));

        issue("rd", 1, 1'b0, 8'h40, 8'h00, 8'd3);
        sb.push_back({8'h11, 1'b1, 1'b0});
        sb.push_back({8'h22, 1'b1, 1'b0});
        sb.push_back({8'h33, 1'b1, 1'b1});
        launch("rd", 1'b0, 8'h40, 8'h00, 8'd3);
        send_byte(8'h11);
        tick();
        send_byte(8'h22);
        send_byte(8'h33);
        pulse_done();
        wait_done("rd", 2'b10, 1'b0);
        chk("rd.level", 32'(fifo_level), 32'(3));
        tick();
        drain_all("rd");

        // Fill the FIFO to 60 so an 8-byte read cannot be admitted
        issue("fill", 0, 1'b0, 8'h00, 8'h00, 8'd60);
        launch("fill", 1'b0, 8'h00, 8'h00, 8'd60);
        for (int i = 0; i < 60; i++) begin
            sb.push_back({8'(i), 1'b0, (i == 59)});
            send_byte(8'(i));
        end
        pulse_done();
        wait_done("fill", 2'b01, 1'b0);
        tick();
        chk("fill.level", 32'(fifo_level), 32'(60));

        set_req(0, 1'b0, 8'h02, 8'h00, 8'd8);
        set_req(1, 1'b1, 8'h55, 8'h66, 8'h00);
        c = 0;
        while (req_ready == '0 && c < 20) begin tick(); c++; end
        chk("adm.wr_grant", 32'(req_ready), 32'(2'b10));
        req_valid[1] = 1'b0;
        launch("adm.wr", 1'b1, 8'h55, 8'h66, 8'h00);
        pulse_done();
        wait_done("adm.wr", 2'b10, 1'b0);
        tick();
        saw = 1'b0;
        repeat (5) begin
            if (req_ready != '0) saw = 1'b1;
            tick();
        end
        chk("adm.blocked", 32'({saw, busy}), 32'(0));
        pop_n("adm.pop", 4);
        c = 0;
        while (req_ready == '0 && c < 10) begin tick(); c++; end
        chk("adm.rd_grant", 32'(req_ready), 32'(2'b01));
        req_valid[0] = 1'b0;
        launch("adm.rd", 1'b0, 8'h02, 8'h00, 8'd8);
        for (int i = 0; i < 8; i++) begin
            sb.push_back({8'(8'h80 + i), 1'b0, (i == 7)});
            send_byte(8'(8'h80 + i));
        end
        pulse_done();
        wait_done("adm.rd", 2'b01, 1'b0);
        chk("adm.level", 32'(fifo_level), 32'(64));
        tick();
        drain_all("adm");

        // Short read with no drv_done: timer starts at 0 in the first launch cycle,
        // expiry is seen at 100, req_done appears one cycle later
        issue("tmo", 0, 1'b0, 8'h30, 8'h00, 8'd2);
        el = 0;
        launch("tmo", 1'b0, 8'h30, 8'h00, 8'd2);
        el += NEWCMD;
        send_byte(8'h5C);
        el++;
        while (req_done == '0 && el < 300) begin tick(); el++; end
        chk("tmo.cycles", 32'(el), 32'(TMO + 1));
        chk("tmo.done", 32'({req_done, req_err}), 32'({2'b01, 1'b1}));
        sb.push_back({8'h5C, 1'b0, 1'b0});
        sb.push_back({8'h00, 1'b0, 1'b1});
        tick();
        drain_all("tmo");

        issue("ovr", 1, 1'b0, 8'h50, 8'h00, 8'd1);
        sb.push_back({8'hE1, 1'b1, 1'b1});
        launch("ovr", 1'b0, 8'h50, 8'h00, 8'd1);
        send_byte(8'hE1);
        send_byte(8'hE2);
        pulse_done();
        wait_done("ovr", 2'b10, 1'b1);
        tick();
        drain_all("ovr");

        issue("zero", 1, 1'b0, 8'h60, 8'h00, 8'd0);
        chk("zero.no_launch", 32'({busy, drv_new_command}), 32'(0));
        tick();
        chk("zero.done", 32'({req_done, req_err}), 32'({2'b10, 1'b0}));
        tick();

        issue("rst", 1, 1'b0, 8'h70, 8'h00, 8'd4);
        launch("rst", 1'b0, 8'h70, 8'h00, 8'd4);
        send_byte(8'h99);
        chk("rst.level1", 32'(fifo_level), 32'(1));
        rstn = 1'b0;
        #1;
        chk("rstw.ctl", 32'({req_ready, req_done, req_err, drv_new_command, busy, rd_valid}), 32'(0));
        chk("rstw.fifo", 32'({fifo_level, rd_data, rd_last, drv_addr, drv_nregs}), 32'(0));
        saw = 1'b0;
        repeat (3) begin
            tick();
            if (req_done != '0) saw = 1'b1;
        end
        chk("rstw.no_done", 32'(saw), 32'(0));
        rstn = 1'b1;
        tick();
        issue("post", 0, 1'b1, 8'h77, 8'h3C, 8'h00);
        launch("post", 1'b1, 8'h77, 8'h3C, 8'h00);
        pulse_done();
        wait_done("post", 2'b01, 1'b0);
        tick();
        chk("post.idle", 32'({busy, fifo_level}), 32'(0));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
